dcache_nway_ctrl: RTL and testbench

Parametrised N-way set-associative, write-through, no-write-allocate data cache controller. It replaces the fixed-geometry data cache between the EX_MEM register and the backing SRAM controller. The pipeline-facing side keeps the existing mem_r_en/mem_w_en/addr/wdata/rdata/ready contract, and the pipeline freezes on ~ready. New relative to the current cache:
- Configurable ways, sets and line length.
- True-LRU replacement.
- Multi-word line fill.
- Global invalidate.
- Hit/miss statistics.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_lru.sv | 45 ++++
 rtl/dcache_nway_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dcache_nway_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the N-way write-through data cache.
// Field extractors take a 64-bit address so one set of functions serves any ADDR_W.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  function automatic int ofw_f(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int ixw_f(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagw_f(input int addr_w, input int line_words, input int sets);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

  function automatic int agew_f(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [63:0] offset_of(input logic [63:0] a, input int ofw);
    return (a >> 2) & ((64'd1 << ofw) - 64'd1);
  endfunction

  function automatic logic [63:0] index_of(input logic [63:0] a, input int ofw, input int ixw);
    return (a >> (2 + ofw)) & ((64'd1 << ixw) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] a, input int ofw, input int ixw);
    return a >> (2 + ofw + ixw);
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age update and victim choice for one set; ages are a permutation of 0..WAYS-1.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int AGEW = agew_f(WAYS)
) (
  input  logic [WAYS-1:0]      valid_i,
  input  logic [WAYS*AGEW-1:0] ages_i,
  input  logic [AGEW-1:0]      acc_way_i,
  input  logic                 acc_i,
  output logic [WAYS*AGEW-1:0] ages_o,
  output logic [AGEW-1:0]      victim_o
);

  logic [AGEW-1:0] old_age;

  always_comb begin
    old_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (acc_way_i == AGEW'(w)) old_age = ages_i[w*AGEW +: AGEW];
    end
  end

  genvar gi;
  for (gi = 0; gi < WAYS; gi++) begin : g_age
    logic [AGEW-1:0] age_w;
    assign age_w = ages_i[gi*AGEW +: AGEW];
    assign ages_o[gi*AGEW +: AGEW] = !acc_i                    ? age_w :
                                     (acc_way_i == AGEW'(gi))  ? '0 :
                                     (age_w < old_age)         ? age_w + 1'b1 : age_w;
  end

  // Oldest way first, then let the lowest-index invalid way override it.
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_i[w*AGEW +: AGEW] == AGEW'(WAYS - 1)) victim_o = AGEW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = AGEW'(w);
    end
  end

endmodule

// File: rtl/dcache_nway_ctrl.sv
// N-way set-associative, write-through, no-write-allocate data cache controller
// with true-LRU replacement, multi-word line fill, global invalidate and hit/miss counters.
module dcache_nway_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic              inv,
  output logic              sram_rd_req,
  output logic              sram_wr_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFW  = ofw_f(LINE_WORDS);
  localparam int OFS  = (OFW > 0) ? OFW : 1;
  localparam int IXW  = ixw_f(SETS);
  localparam int TAGW = tagw_f(ADDR_W, LINE_WORDS, SETS);
  localparam int AGEW = agew_f(WAYS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_rd_q, inv_pend_q;
  logic [OFS-1:0]    cnt_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  logic [DATA_W-1:0]    data_q  [WAYS][SETS][LINE_WORDS];
  logic [TAGW-1:0]      tag_q   [WAYS][SETS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS*AGEW-1:0] age_q   [SETS];
  logic [DATA_W-1:0]    fill_q  [LINE_WORDS];

  logic [WAYS*AGEW-1:0] age_init, lru_ages;
  logic [AGEW-1:0]      hit_way, victim, acc_way;
  logic                 hit, lru_acc, inv_apply;
  logic                 rd_hit, rd_miss, wr_start, fill_ack, fill_last, wr_ack_hit, done_exit;
  logic [ADDR_W-1:0]    look_addr, line_base;
  logic [OFS-1:0]       look_off;
  logic [IXW-1:0]       look_idx;
  logic [TAGW-1:0]      look_tag;

  genvar gi;
  for (gi = 0; gi < WAYS; gi++) begin : g_age_init
    assign age_init[gi*AGEW +: AGEW] = AGEW'(gi);
  end

  // In IDLE the live request is looked up; otherwise the latched one.
  assign look_addr = (state_q == IDLE) ? addr : addr_q;
  assign look_off  = OFS'(offset_of(64'(look_addr), OFW));
  assign look_idx  = IXW'(index_of(64'(look_addr), OFW, IXW));
  assign look_tag  = TAGW'(tag_of(64'(look_addr), OFW, IXW));
  assign line_base = addr_q & ~ADDR_W'(LINE_WORDS * 4 - 1);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[look_idx][w] && tag_q[w][look_idx] == look_tag) begin
        hit     = 1'b1;
        hit_way = AGEW'(w);
      end
    end
  end

  assign acc_way = (state_q == FILL) ? victim : hit_way;
  assign lru_acc = rd_hit || fill_last || wr_ack_hit;

  dcache_lru #(.WAYS(WAYS), .AGEW(AGEW)) u_lru (
    .valid_i   (valid_q[look_idx]),
    .ages_i    (age_q[look_idx]),
    .acc_way_i (acc_way),
    .acc_i     (lru_acc),
    .ages_o    (lru_ages),
    .victim_o  (victim)
  );

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    rdata       = '0;
    sram_rd_req = 1'b0;
    sram_wr_req = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    wr_start    = 1'b0;
    fill_ack    = 1'b0;
    fill_last   = 1'b0;
    wr_ack_hit  = 1'b0;
    done_exit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_w_en) begin
          wr_start = 1'b1;
          state_d  = WRITE;
        end else if (mem_r_en) begin
          if (hit && !inv) begin
            rd_hit = 1'b1;
            ready  = 1'b1;
            rdata  = data_q[hit_way][look_idx][look_off];
          end else begin
            rd_miss = 1'b1;
            state_d = FILL;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL: begin
        sram_rd_req = 1'b1;
        sram_addr   = line_base | ADDR_W'({cnt_q, 2'b00});
        if (sram_ack) begin
          fill_ack = 1'b1;
          if (cnt_q == OFS'(LINE_WORDS - 1)) begin
            fill_last = 1'b1;
            state_d   = DONE;
          end
        end
      end
      WRITE: begin
        sram_wr_req = 1'b1;
        sram_addr   = addr_q;
        sram_wdata  = wdata_q;
        if (sram_ack) begin
          wr_ack_hit = hit;
          state_d    = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        rdata     = is_rd_q ? fill_q[look_off] : '0;
        done_exit = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A deferred invalidate lands as DONE exits, discarding the line just filled.
  assign inv_apply = (state_q == IDLE && inv) || (done_exit && (inv_pend_q || inv));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_rd_q    <= 1'b0;
      inv_pend_q <= 1'b0;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (rd_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (rd_miss || wr_start) begin
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        is_rd_q <= rd_miss;
        cnt_q   <= '0;
      end
      if (wr_start) wdata_q <= wdata;
      if (fill_ack) cnt_q <= cnt_q + 1'b1;
      if (done_exit) inv_pend_q <= 1'b0;
      else if (state_q != IDLE && inv) inv_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || inv_apply) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= age_init;
      end
    end else if (lru_acc) begin
      age_q[look_idx] <= lru_ages;
      if (fill_last) valid_q[look_idx][victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_ack) fill_q[cnt_q] <= sram_rdata;
    if (fill_last) begin
      tag_q[victim][look_idx] <= look_tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_q[victim][look_idx][w] <= (OFS'(w) == cnt_q) ? sram_rdata : fill_q[w];
      end
    end
    if (wr_ack_hit) data_q[hit_way][look_idx][look_off] <= wdata_q;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dcache_nway_ctrl.sv
// Directed bench for dcache_nway_ctrl (WAYS=2, SETS=4, LINE_WORDS=2; index = addr[4:3]).
// Backing memory word i holds 0xAAAA0000 + i - 3, so 0x10 -> 0xAAAA0001, 0x14 -> 0xAAAA0002.
module tb_dcache_nway_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0, inv = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_req, sram_wr_req, sram_ack;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];
  logic [31:0] rd_acks [$];
  int          lat = 2;
  int          wait_cnt = 0;
  int          wr_acks = 0;
  logic [31:0] wd_first = '0;
  bit          wd_unstable = 1'b0;

  always #5 clk = ~clk;

  dcache_nway_ctrl #(
    .ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(4), .LINE_WORDS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .inv(inv),
    .sram_rd_req(sram_rd_req), .sram_wr_req(sram_wr_req),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Backing SRAM: acks in the lat-th cycle of each request.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hAAAA0000 + 32'(i) - 32'd3;
    sram_ack   = 1'b0;
    sram_rdata = '0;
    forever begin
      @(negedge clk);
      sram_ack = 1'b0;
      if (sram_rd_req || sram_wr_req) begin
        wait_cnt++;
        if (sram_wr_req) begin
          if (wait_cnt == 1) wd_first = sram_wdata;
          else if (sram_wdata !== wd_first) wd_unstable = 1'b1;
        end
        if (wait_cnt >= lat) begin
          sram_ack = 1'b1;
          wait_cnt = 0;
          if (sram_wr_req) begin
            mem[sram_addr[7:2]] = sram_wdata;
            wr_acks++;
          end else begin
            sram_rdata = mem[sram_addr[7:2]];
            rd_acks.push_back(sram_addr);
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Presents a read until ready; inv is pulsed in the cycle whose wait index equals inv_at.
  task automatic do_read(input logic [31:0] a, input int inv_at, output logic [31:0] d, output int waits);
    mem_r_en = 1'b1;
    addr     = a;
    waits    = 0;
    d        = '0;
    forever begin
      inv = (waits == inv_at);
      #1;
      if (ready) begin
        d = rdata;
        break;
      end
      @(negedge clk);
      waits++;
      if (waits > 60) break;
    end
    $display("read  %h -> %h after %0d wait cycles", a, d, waits);
    @(negedge clk);
    mem_r_en = 1'b0;
    inv      = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] v, output int waits);
    mem_w_en = 1'b1;
    addr     = a;
    wdata    = v;
    waits    = 0;
    forever begin
      #1;
      if (ready) break;
      @(negedge clk);
      waits++;
      if (waits > 60) break;
    end
    $display("write %h <- %h after %0d wait cycles", a, v, waits);
    @(negedge clk);
    mem_w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    vectors++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    vectors++; if (sram_rd_req !== 1'b0 || sram_wr_req !== 1'b0 || sram_addr !== 32'h0 || sram_wdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_sram: got rd=%b wr=%b a=%h d=%h want all 0", sram_rd_req, sram_wr_req, sram_addr, sram_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_miss_fill();
    logic [31:0] d;
    int          w;
    rd_acks.delete();
    do_read(32'h10, -1, d, w);
    vectors++; if (d !== 32'hAAAA0001) begin miscompares++; $display("FAIL fill_rdata: got %h want aaaa0001", d); end
    vectors++; if (w != 5) begin miscompares++; $display("FAIL fill_latency: got %0d want 5", w); end
    vectors++; if (rd_acks.size() != 2) begin miscompares++; $display("FAIL fill_req_count: got %0d want 2", rd_acks.size()); end
    else begin
      vectors++; if (rd_acks[0] !== 32'h10 || rd_acks[1] !== 32'h14) begin
        miscompares++; $display("FAIL fill_addrs: got %h,%h want 00000010,00000014", rd_acks[0], rd_acks[1]);
      end
    end
    vectors++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin miscompares++; $display("FAIL fill_counters: got hit %0d miss %0d want 0/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_hit();
    logic [31:0] d;
    int          w;
    rd_acks.delete();
    do_read(32'h14, -1, d, w);
    vectors++; if (w != 0) begin miscompares++; $display("FAIL hit_latency: got %0d want 0", w); end
    vectors++; if (d !== 32'hAAAA0002) begin miscompares++; $display("FAIL hit_rdata: got %h want aaaa0002", d); end
    vectors++; if (rd_acks.size() != 0) begin miscompares++; $display("FAIL hit_no_sram: got %0d reads want 0", rd_acks.size()); end
    vectors++; if (hit_cnt !== 32'd1) begin miscompares++; $display("FAIL hit_count: got %0d want 1", hit_cnt); end
  endtask

  task automatic test_lru();
    logic [31:0] d;
    int          w;
    do_read(32'h30, -1, d, w);
    vectors++; if (w != 5 || d !== 32'hAAAA0009) begin miscompares++; $display("FAIL lru_fill30: got %h/%0d want aaaa0009/5", d, w); end
    do_read(32'h10, -1, d, w);
    vectors++; if (w != 0 || d !== 32'hAAAA0001) begin miscompares++; $display("FAIL lru_hit10: got %h/%0d want aaaa0001/0", d, w); end
    do_read(32'h50, -1, d, w);
    vectors++; if (w != 5 || d !== 32'hAAAA0011) begin miscompares++; $display("FAIL lru_fill50: got %h/%0d want aaaa0011/5", d, w); end
    do_read(32'h10, -1, d, w);
    vectors++; if (w != 0) begin miscompares++; $display("FAIL lru_keep10: got %0d waits want 0", w); end
    do_read(32'h30, -1, d, w);
    vectors++; if (w != 5 || d !== 32'hAAAA0009) begin miscompares++; $display("FAIL lru_evicted30: got %h/%0d want aaaa0009/5", d, w); end
    vectors++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd4) begin miscompares++; $display("FAIL lru_counters: got hit %0d miss %0d want 3/4", hit_cnt, miss_cnt); end
  endtask

  task automatic test_write();
    logic [31:0] d;
    int          w;
    int          acks0;
    lat         = 4;
    wd_unstable = 1'b0;
    acks0       = wr_acks;
    do_write(32'h10, 32'h12345678, w);
    lat = 2;
    vectors++; if (w != 5) begin miscompares++; $display("FAIL wr_latency: got %0d want 5", w); end
    vectors++; if (wd_unstable !== 1'b0) begin miscompares++; $display("FAIL wr_wdata_stable: got unstable want stable"); end
    vectors++; if (wr_acks != acks0 + 1 || mem[4] !== 32'h12345678) begin
      miscompares++; $display("FAIL wr_sram: got %0d writes mem %h want 1 / 12345678", wr_acks - acks0, mem[4]);
    end
    do_read(32'h10, -1, d, w);
    vectors++; if (w != 0 || d !== 32'h12345678) begin miscompares++; $display("FAIL wr_hit_update: got %h/%0d want 12345678/0", d, w); end
    do_write(32'h70, 32'hCAFEF00D, w);
    do_read(32'h70, -1, d, w);
    vectors++; if (w != 5 || d !== 32'hCAFEF00D) begin miscompares++; $display("FAIL wr_no_allocate: got %h/%0d want cafef00d/5", d, w); end
  endtask

  task automatic test_inv();
    logic [31:0] d;
    int          w;
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    do_read(32'h14, -1, d, w);
    vectors++; if (w != 5 || d !== 32'hAAAA0002) begin miscompares++; $display("FAIL inv_idle_refill: got %h/%0d want aaaa0002/5", d, w); end
    do_read(32'h10, 0, d, w);
    vectors++; if (w != 5 || d !== 32'h12345678) begin miscompares++; $display("FAIL inv_same_cycle_miss: got %h/%0d want 12345678/5", d, w); end
    do_read(32'h90, 2, d, w);
    vectors++; if (w != 5 || d !== 32'hAAAA0021) begin miscompares++; $display("FAIL inv_fill_data: got %h/%0d want aaaa0021/5", d, w); end
    do_read(32'h90, -1, d, w);
    vectors++; if (w != 5) begin miscompares++; $display("FAIL inv_fill_discard: got %0d waits want 5", w); end
    vectors++; if (hit_cnt !== 32'd4 || miss_cnt !== 32'd9) begin miscompares++; $display("FAIL inv_counters: got hit %0d miss %0d want 4/9", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d;
    int          w;
    int          n;
    rd_acks.delete();
    mem_r_en = 1'b1;
    addr     = 32'hB0;
    n        = 0;
    while (rd_acks.size() == 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++; if (rd_acks.size() != 1) begin miscompares++; $display("FAIL rstfill_first_ack: got %0d acks want 1", rd_acks.size()); end
    @(negedge clk);
    rst      = 1'b1;
    mem_r_en = 1'b0;
    @(negedge clk);
    #1;
    vectors++; if (sram_rd_req !== 1'b0) begin miscompares++; $display("FAIL rstfill_req_drop: got %b want 0", sram_rd_req); end
    vectors++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin miscompares++; $display("FAIL rstfill_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rstfill_ready: got %b want 1", ready); end
    rst = 1'b0;
    @(negedge clk);
    do_read(32'h10, -1, d, w);
    vectors++; if (w != 5 || d !== 32'h12345678) begin miscompares++; $display("FAIL rstfill_cold_miss: got %h/%0d want 12345678/5", d, w); end
    vectors++; if (miss_cnt !== 32'd1) begin miscompares++; $display("FAIL rstfill_miss_count: got %0d want 1", miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_lru();
    test_write();
    test_inv();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
